// File: rtl/exmem_latency_pipe_if.sv
// Request/response bundle between a bus master and the latency-pipe memory model.
// Master drives the request fields; the slave returns stall and the completion pulses.
interface exmem_latency_pipe_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   localparam int NB = DW / 8;

   logic          stb;
   logic          we;
   logic [NB-1:0] sel;
   logic [DW-1:0] dat_i;
   logic [AW-1:0] addr;
   logic          stall;
   logic          ack;
   logic          err;
   logic [DW-1:0] dat_o;

   modport master (
      output stb, we, sel, dat_i, addr,
      input  stall, ack, err, dat_o
   );

   modport slave (
      input  stb, we, sel, dat_i, addr,
      output stall, ack, err, dat_o
   );
endinterface

// File: rtl/exmem_latency_pipe.sv
// Wishbone-style slave memory model: every accepted request completes exactly LATENCY
// cycles later (ack in window, err outside), in order, with a cap on in-flight requests.
module exmem_latency_pipe #(
   parameter int          DW      = 32,
   parameter int          AW      = 32,
   parameter int          DEPTH   = 1024,
   parameter int          LATENCY = 10,
   parameter int          MAX_OUT = LATENCY,
   parameter logic [AW-1:0] BASE  = 32'h3800_0000
) (
   input logic                 clk,
   input logic                 rst,
   exmem_latency_pipe_if.slave bus
);
   localparam int NB = DW / 8;
   localparam int LB = $clog2(NB);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);
   // One extra bit so the window end cannot wrap at the top of the address space.
   localparam logic [AW:0]   WIN_LO  = {1'b0, BASE};
   localparam logic [AW:0]   WIN_HI  = WIN_LO + (AW+1)'(DEPTH * NB);

   typedef struct packed {
      logic          valid;
      logic          we;
      logic [NB-1:0] sel;
      logic [DW-1:0] dat;
      logic [IW-1:0] idx;
      logic          inwin;
   } stage_t;

   logic [DW-1:0] mem [DEPTH];
   stage_t        pipe [LATENCY];
   stage_t        incoming;
   stage_t        last;
   logic [CW-1:0] cnt;
   logic [AW:0]   addr_ext;
   logic          stall;
   logic          accept;
   logic          retire;

   assign stall     = (cnt == CNT_MAX);
   assign bus.stall = stall;

   // Request decode: window check, accept qualification and the stage-0 payload.
   always_comb begin
      addr_ext       = {1'b0, bus.addr};
      accept         = bus.stb && !stall;
      // A request retires on the edge that launches its final stage, so its slot
      // is free again by the time its ack/err edge arrives.
      retire         = pipe[LATENCY-2].valid;
      last           = pipe[LATENCY-1];
      incoming.valid = 1'b1;
      incoming.we    = bus.we;
      incoming.sel   = bus.sel;
      incoming.dat   = bus.dat_i;
      incoming.idx   = bus.addr[LB+IW-1:LB];
      incoming.inwin = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
   end

   // Request k sits in pipe[k] during the k-th cycle after its accept edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe[i] <= '0;
         end
      end else begin
         pipe[0] <= accept ? incoming : '0;
         for (int i = 1; i < LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   // In-flight counter driving stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         case ({accept, retire})
            2'b10:   cnt <= cnt + CNT_ONE;
            2'b01:   cnt <= cnt - CNT_ONE;
            default: cnt <= cnt;
         endcase
      end
   end

   // Byte-lane write port fed by the final stage; contents survive reset.
   always_ff @(posedge clk) begin
      if (last.valid && last.inwin && last.we) begin
         for (int b = 0; b < NB; b++) begin
            if (last.sel[b]) begin
               mem[last.idx][b*8 +: 8] <= last.dat[b*8 +: 8];
            end
         end
      end
   end

   // Registered completion: read data lands on the same edge as ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.ack   <= 1'b0;
         bus.err   <= 1'b0;
         bus.dat_o <= '0;
      end else begin
         bus.ack   <= last.valid && last.inwin;
         bus.err   <= last.valid && !last.inwin;
         bus.dat_o <= (last.valid && last.inwin && !last.we) ? mem[last.idx] : '0;
      end
   end
endmodule

// File: tb/tb_exmem_latency_pipe.sv
// Randomised and directed checks of exmem_latency_pipe against a transaction-level model
// (expected-completion queue plus a word-addressed memory image).
module tb_exmem_latency_pipe;
   localparam int          L     = 10;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h3800_0000;
   localparam longint      WIN   = DEPTH * 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   exmem_latency_pipe_if #(.DW(32), .AW(32)) bus ();
   exmem_latency_pipe_if #(.DW(32), .AW(32)) bbus ();

   exmem_latency_pipe #(.DW(32), .AW(32), .DEPTH(DEPTH), .LATENCY(L), .MAX_OUT(L), .BASE(BASE))
      u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

   exmem_latency_pipe #(.DW(32), .AW(32), .DEPTH(DEPTH), .LATENCY(L), .MAX_OUT(1), .BASE(BASE))
      u_blk (.clk(clk), .rst(rst), .bus(bbus.slave));

   typedef struct {
      int          due;
      bit          is_err;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mm[int];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Requests not yet retired: a request retires one cycle before its completion.
   function automatic bit model_stall();
      int n = 0;
      foreach (exp_q[i]) if (exp_q[i].due > cyc + 1) n++;
      return n == L;
   endfunction

   task automatic idle();
      bus.stb = 1'b0; bus.we = 1'b0; bus.sel = 4'h0; bus.dat_i = 32'h0; bus.addr = 32'h0;
   endtask

   task automatic drv(input bit we, input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] d);
      bus.stb = 1'b1; bus.we = we; bus.sel = sel; bus.dat_i = d; bus.addr = addr;
   endtask

   // One clock: update the model on the accept edge, then check every output at negedge.
   task automatic step();
      bit          acc;
      bit          we;
      logic [3:0]  sel;
      logic [31:0] d;
      logic [31:0] w;
      longint      a;
      int          idx;
      exp_t        e;
      logic [31:0] ack_e, err_e, dat_e;
      acc = bus.stb && !model_stall() && !rst;
      we  = bus.we; sel = bus.sel; d = bus.dat_i;
      a   = longint'({32'h0, bus.addr});
      @(posedge clk);
      cyc++;
      if (acc) begin
         e.due = cyc + L;
         if (a < longint'(BASE) || a >= longint'(BASE) + WIN) begin
            e.is_err = 1'b1; e.data = 32'h0;
         end else begin
            e.is_err = 1'b0;
            idx = int'((a - longint'(BASE)) / 4);
            if (we) begin
               w = mm.exists(idx) ? mm[idx] : 32'h0;
               for (int b = 0; b < 4; b++) if (sel[b]) w[b*8 +: 8] = d[b*8 +: 8];
               mm[idx] = w;
               e.data = 32'h0;
            end else begin
               e.data = mm.exists(idx) ? mm[idx] : 32'h0;
            end
         end
         exp_q.push_back(e);
      end
      @(negedge clk);
      ack_e = 32'h0; err_e = 32'h0; dat_e = 32'h0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         ack_e = {31'h0, !e.is_err}; err_e = {31'h0, e.is_err}; dat_e = e.data;
      end
      chk("ack", {31'h0, bus.ack}, ack_e);
      chk("err", {31'h0, bus.err}, err_e);
      chk("dat_o", bus.dat_o, dat_e);
      chk("stall", {31'h0, bus.stall}, {31'h0, model_stall()});
   endtask

   // Single isolated transaction with explicit latency, completion kind and data checks.
   task automatic single(input string tag, input bit we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] d, input bit exp_err, input logic [31:0] exp_dat);
      int          t0;
      int          lat = -1;
      bit          seen_err = 1'b0;
      logic [31:0] got_dat = 32'hx;
      drv(we, addr, sel, d);
      step();
      t0 = cyc;
      idle();
      for (int k = 0; k < 2 * L; k++) begin
         step();
         if ((bus.ack || bus.err) && lat < 0) begin
            lat = cyc - t0; seen_err = bus.err; got_dat = bus.dat_o;
         end
      end
      chk({tag, "_lat"}, lat, L);
      chk({tag, "_kind"}, {31'h0, seen_err}, {31'h0, exp_err});
      chk({tag, "_dat"}, got_dat, exp_dat);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      bbus.stb = 1'b0; bbus.we = 1'b0; bbus.sel = 4'hF; bbus.dat_i = 32'h0; bbus.addr = BASE;
      repeat (2) @(negedge clk);
      chk("rst_ack", {31'h0, bus.ack}, 32'h0);
      chk("rst_err", {31'h0, bus.err}, 32'h0);
      chk("rst_dat", bus.dat_o, 32'h0);
      chk("rst_stall", {31'h0, bus.stall}, 32'h0);
      rst = 1'b0;

      // Reset while three reads are in flight: they must vanish.
      for (int i = 0; i < 3; i++) begin
         drv(1'b0, BASE + 32'(4 * i), 4'hF, 32'h0);
         step();
      end
      idle();
      step();
      #2 rst = 1'b1;
      exp_q.delete();
      step();
      rst = 1'b0;
      repeat (15) step();

      single("w0", 1'b1, BASE, 4'hF, 32'hA5A5_0001, 1'b0, 32'h0);
      single("wdead", 1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0);
      single("rdead", 1'b0, BASE + 32'h10, 4'h0, 32'h0, 1'b0, 32'hDEAD_BEEF);
      single("rdead_unal", 1'b0, BASE + 32'h13, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF);
      single("wff", 1'b1, BASE + 32'h4, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0);
      single("wlane", 1'b1, BASE + 32'h4, 4'b0101, 32'h1122_3344, 1'b0, 32'h0);
      single("rlane", 1'b0, BASE + 32'h4, 4'hF, 32'h0, 1'b0, 32'hFF22_FF44);
      single("rlow", 1'b0, BASE - 32'h4, 4'hF, 32'h0, 1'b1, 32'h0);
      single("rhigh", 1'b0, BASE + 32'(WIN), 4'hF, 32'h0, 1'b1, 32'h0);
      single("whigh", 1'b1, BASE + 32'(WIN), 4'hF, 32'h1234_5678, 1'b1, 32'h0);
      single("rw0", 1'b0, BASE, 4'hF, 32'h0, 1'b0, 32'hA5A5_0001);

      // Back-to-back streaming: ten writes then ten reads with no gaps.
      for (int i = 0; i < 10; i++) begin
         drv(1'b1, BASE + 32'h100 + 32'(4 * i), 4'hF, $urandom);
         step();
      end
      for (int i = 0; i < 10; i++) begin
         drv(1'b0, BASE + 32'h100 + 32'(4 * i), 4'hF, 32'h0);
         step();
      end
      idle();
      repeat (L + 2) step();

      // Randomised mix over a small region, seeded by full-word writes.
      for (int i = 0; i < 16; i++) begin
         drv(1'b1, BASE + 32'h200 + 32'(4 * i), 4'hF, $urandom);
         step();
      end
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle();
         end else if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 1)
               drv(1'($urandom_range(0, 1)), BASE - 32'(4 * $urandom_range(1, 64)), 4'hF, $urandom);
            else
               drv(1'($urandom_range(0, 1)), BASE + 32'(WIN) + 32'(4 * $urandom_range(0, 64)), 4'hF, $urandom);
         end else begin
            drv(1'($urandom_range(0, 1)),
                BASE + 32'h200 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)), $urandom);
         end
         step();
      end
      idle();
      repeat (L + 2) step();

      // Blocking-mode instance: stb held for two reads.
      bbus.stb = 1'b1;
      for (int j = 1; j <= 2 * L + 3; j++) begin
         step();
         chk("blk_stall", {31'h0, bbus.stall},
             {31'h0, ((j >= 1 && j <= L - 1) || (j >= L + 1 && j <= 2 * L - 1))});
         chk("blk_ack", {31'h0, bbus.ack}, {31'h0, (j == L + 1) || (j == 2 * L + 1)});
         chk("blk_err", {31'h0, bbus.err}, 32'h0);
         if (j == L + 1) bbus.stb = 1'b0;
      end

      chk("drain", exp_q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
